// File: rtl/fixed_cast_pkg.sv
// Shared helpers for the fixed-point floor/saturate cast.
// Provides the rounding-stage width and the output clamp limits.
package fixed_cast_pkg;

    // Width of the rounding-stage result: left shifts grow the word, right shifts do not.
    function automatic int unsigned calc_rw(
        input int unsigned in_w,
        input int unsigned in_f,
        input int unsigned out_f
    );
        return (out_f >= in_f) ? (in_w + (out_f - in_f)) : in_w;
    endfunction

    // Largest representable output value.
    function automatic longint sat_max(input int unsigned out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    // Smallest allowed output value; the symmetric range drops the most negative code.
    function automatic longint sat_min(input int unsigned out_w, input bit symmetric);
        return symmetric ? -sat_max(out_w) : (-sat_max(out_w) - longint'(1));
    endfunction

endpackage

// File: rtl/fixed_floor_shift.sv
// Rounding stage: aligns the input binary point to the output fraction width.
// Ports: in_data (IN_WIDTH, signed)  -> value (RW, signed).
// Left shift is exact; right shift is arithmetic, i.e. floor toward -inf.
module fixed_floor_shift
    import fixed_cast_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned IN_FRAC_WIDTH  = 4,
    parameter int unsigned OUT_FRAC_WIDTH = 4,
    localparam int unsigned RW = calc_rw(IN_WIDTH, IN_FRAC_WIDTH, OUT_FRAC_WIDTH)
) (
    input  logic [IN_WIDTH-1:0] in_data,
    output logic [RW-1:0]       value
);

    if (OUT_FRAC_WIDTH >= IN_FRAC_WIDTH) begin : g_shl
        localparam int unsigned SHL = OUT_FRAC_WIDTH - IN_FRAC_WIDTH;
        // Sign-extend first so the shifted-in integer bits keep the sign.
        assign value = RW'($signed(in_data)) << SHL;
    end else begin : g_asr
        localparam int unsigned SHR = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
        assign value = RW'($signed(in_data) >>> SHR);
    end

endmodule

// File: rtl/fixed_floor_sat_cast.sv
// Registered signed fixed-point format converter (floor, then saturate).
// Ports:
//   clk, rst_n            clock / async active-low reset
//   in_data, in_valid     input sample stream
//   in_ready              accept indication (combinational from output state)
//   out_data, out_valid   registered converted sample
//   out_ready             downstream accept
//   out_sat               (only with FIXED_CAST_SAT_FLAG_EN) sample was clamped
module fixed_floor_sat_cast
    import fixed_cast_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned IN_FRAC_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned OUT_FRAC_WIDTH = 4,
    parameter bit          SYMMETRIC      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef FIXED_CAST_SAT_FLAG_EN
    ,
    output logic                 out_sat
`endif
);

    localparam int unsigned RW = calc_rw(IN_WIDTH, IN_FRAC_WIDTH, OUT_FRAC_WIDTH);
    // One spare bit over the wider of RW/OUT_WIDTH keeps both limits and the value representable.
    localparam int unsigned CW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;
    localparam logic signed [CW-1:0] MAX_V = CW'(sat_max(OUT_WIDTH));
    localparam logic signed [CW-1:0] MIN_V = CW'(sat_min(OUT_WIDTH, SYMMETRIC));

    logic [RW-1:0]          value;
    logic signed [CW-1:0]   value_ext;
    logic                   over_c;
    logic                   under_c;
    logic [OUT_WIDTH-1:0]   clamp_c;
    logic                   load;

    fixed_floor_shift #(
        .IN_WIDTH       (IN_WIDTH),
        .IN_FRAC_WIDTH  (IN_FRAC_WIDTH),
        .OUT_FRAC_WIDTH (OUT_FRAC_WIDTH)
    ) u_shift (
        .in_data (in_data),
        .value   (value)
    );

    // Clamp to the output range; in-range values keep their low OUT_WIDTH bits.
    always_comb begin
        value_ext = CW'($signed(value));
        over_c    = (value_ext > MAX_V);
        under_c   = (value_ext < MIN_V);
        clamp_c   = value_ext[OUT_WIDTH-1:0];
        if (over_c) begin
            clamp_c = MAX_V[OUT_WIDTH-1:0];
        end else if (under_c) begin
            clamp_c = MIN_V[OUT_WIDTH-1:0];
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Single-entry output register; a pop with a simultaneous push reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= clamp_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FIXED_CAST_SAT_FLAG_EN
    // Saturation flag travels with the data it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat <= 1'b0;
        end else if (load) begin
            out_sat <= over_c || under_c;
        end
    end
`endif

endmodule

// File: tb/tb_fixed_floor_sat_cast.sv
// Bench for fixed_floor_sat_cast: four instances (default identity, 8/4->4/1
// asymmetric and symmetric, 4/0->8/2) driven in lockstep and compared against
// a real-arithmetic floor/clamp model with a one-entry handshake model.
module tb_fixed_floor_sat_cast;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_a;
    logic [3:0] in_b;

    logic       rdy_a, rdy_b, rdy_c, rdy_d;
    logic       vld_a, vld_b, vld_c, vld_d;
    logic [7:0] dat_a;
    logic [3:0] dat_b;
    logic [3:0] dat_c;
    logic [7:0] dat_d;
`ifdef FIXED_CAST_SAT_FLAG_EN
    logic       sat_a, sat_b, sat_c, sat_d;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Expected state of every instance's output register
    bit      mdl_valid;
    longint  exp_a, exp_b, exp_c, exp_d;
    bit      xs_a, xs_b, xs_c, xs_d;

    fixed_floor_sat_cast u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_a), .in_valid(in_valid),
        .in_ready(rdy_a), .out_data(dat_a), .out_valid(vld_a), .out_ready(out_ready)
`ifdef FIXED_CAST_SAT_FLAG_EN
        , .out_sat(sat_a)
`endif
    );

    fixed_floor_sat_cast #(
        .IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(4), .OUT_FRAC_WIDTH(1), .SYMMETRIC(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_a), .in_valid(in_valid),
        .in_ready(rdy_b), .out_data(dat_b), .out_valid(vld_b), .out_ready(out_ready)
`ifdef FIXED_CAST_SAT_FLAG_EN
        , .out_sat(sat_b)
`endif
    );

    fixed_floor_sat_cast #(
        .IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(4), .OUT_FRAC_WIDTH(1), .SYMMETRIC(1'b1)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_a), .in_valid(in_valid),
        .in_ready(rdy_c), .out_data(dat_c), .out_valid(vld_c), .out_ready(out_ready)
`ifdef FIXED_CAST_SAT_FLAG_EN
        , .out_sat(sat_c)
`endif
    );

    fixed_floor_sat_cast #(
        .IN_WIDTH(4), .IN_FRAC_WIDTH(0), .OUT_WIDTH(8), .OUT_FRAC_WIDTH(2), .SYMMETRIC(1'b0)
    ) u_dut_d (
        .clk(clk), .rst_n(rst_n), .in_data(in_b), .in_valid(in_valid),
        .in_ready(rdy_d), .out_data(dat_d), .out_valid(vld_d), .out_ready(out_ready)
`ifdef FIXED_CAST_SAT_FLAG_EN
        , .out_sat(sat_d)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // floor(x * 2^outf / 2^inf) as plain arithmetic on the real value
    function automatic longint ref_floor(input longint x, input int inf, input int outf);
        real r;
        r = $floor(real'(x) * real'(longint'(1) <<< outf) / real'(longint'(1) <<< inf));
        return longint'(r);
    endfunction

    function automatic longint ref_cast(input longint x, input int inf, input int outw,
                                        input int outf, input bit sym, output bit sat);
        longint v, mx, mn;
        v   = ref_floor(x, inf, outf);
        mx  = (longint'(1) <<< (outw - 1)) - 1;
        mn  = sym ? -mx : -mx - 1;
        sat = (v > mx) || (v < mn);
        if (v > mx) v = mx;
        if (v < mn) v = mn;
        return v & ((longint'(1) <<< outw) - 1);
    endfunction

    task automatic reset_model();
        mdl_valid = 1'b0;
        exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0;
        xs_a = 1'b0; xs_b = 1'b0; xs_c = 1'b0; xs_d = 1'b0;
    endtask

    task automatic check_outputs();
        check("valid_a", longint'(vld_a), longint'(mdl_valid));
        check("valid_b", longint'(vld_b), longint'(mdl_valid));
        check("valid_c", longint'(vld_c), longint'(mdl_valid));
        check("valid_d", longint'(vld_d), longint'(mdl_valid));
        check("data_a", longint'(dat_a), exp_a);
        check("data_b", longint'(dat_b), exp_b);
        check("data_c", longint'(dat_c), exp_c);
        check("data_d", longint'(dat_d), exp_d);
`ifdef FIXED_CAST_SAT_FLAG_EN
        check("sat_a", longint'(sat_a), longint'(xs_a));
        check("sat_b", longint'(sat_b), longint'(xs_b));
        check("sat_c", longint'(sat_c), longint'(xs_c));
        check("sat_d", longint'(sat_d), longint'(xs_d));
`endif
    endtask

    // One clock: check outputs, drive inputs, check ready, advance the model.
    task automatic cycle(input bit v, input bit r, input logic [7:0] a, input logic [3:0] b);
        bit push;
        bit s;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        out_ready = r;
        in_a      = a;
        in_b      = b;
        #1;
        check("ready_a", longint'(rdy_a), longint'(!mdl_valid || r));
        check("ready_b", longint'(rdy_b), longint'(!mdl_valid || r));
        check("ready_c", longint'(rdy_c), longint'(!mdl_valid || r));
        check("ready_d", longint'(rdy_d), longint'(!mdl_valid || r));
        push = v && (!mdl_valid || r);
        if (push) begin
            exp_a = ref_cast(longint'($signed(a)), 4, 8, 4, 1'b0, s); xs_a = s;
            exp_b = ref_cast(longint'($signed(a)), 4, 4, 1, 1'b0, s); xs_b = s;
            exp_c = ref_cast(longint'($signed(a)), 4, 4, 1, 1'b1, s); xs_c = s;
            exp_d = ref_cast(longint'($signed(b)), 0, 8, 2, 1'b0, s); xs_d = s;
            mdl_valid = 1'b1;
        end else if (mdl_valid && r) begin
            mdl_valid = 1'b0;
        end
    endtask

    // Push one sample, let it land, then compare against hand-derived literals.
    task automatic directed(input logic [7:0] a, input logic [3:0] b, input longint ea,
                            input longint eb, input longint ec, input longint ed);
        cycle(1'b1, 1'b1, a, b);
        cycle(1'b0, 1'b1, 8'h00, 4'h0);
        check("lit_a", longint'(dat_a), ea);
        check("lit_b", longint'(dat_b), eb);
        check("lit_c", longint'(dat_c), ec);
        check("lit_d", longint'(dat_d), ed);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 8'h00;
        in_b      = 4'h0;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_valid", longint'(vld_a), 0);
        check("rst_data", longint'(dat_a), 0);
        check("rst_ready", longint'(rdy_a), 1);
        rst_n = 1'b1;

        // Rounding, saturation and left-shift corner cases
        directed(8'h2C, 4'h9, 64'h2C, 64'h5, 64'h5, 64'hE4);
        directed(8'hFF, 4'h7, 64'hFF, 64'hF, 64'hF, 64'h1C);
        directed(8'h7F, 4'h9, 64'h7F, 64'h7, 64'h7, 64'hE4);
        directed(8'h80, 4'h7, 64'h80, 64'h8, 64'h9, 64'h1C);

        // Back-to-back stream, one per cycle
        cycle(1'b1, 1'b1, 8'h00, 4'h0);
        cycle(1'b1, 1'b1, 8'h7F, 4'h7);
        cycle(1'b1, 1'b1, 8'h80, 4'h8);
        cycle(1'b1, 1'b1, 8'h13, 4'h3);
        cycle(1'b0, 1'b1, 8'h00, 4'h0);

        // Backpressure: held sample must stay put while new input waits
        cycle(1'b1, 1'b0, 8'h35, 4'h5);
        cycle(1'b1, 1'b0, 8'hA1, 4'hA);
        cycle(1'b1, 1'b0, 8'hA1, 4'hA);
        cycle(1'b1, 1'b0, 8'hA1, 4'hA);
        cycle(1'b1, 1'b1, 8'hA1, 4'hA);
        cycle(1'b0, 1'b1, 8'h00, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  8'($urandom), 4'($urandom));
        end

        // Asynchronous reset while a sample is held
        cycle(1'b1, 1'b0, 8'h13, 4'h7);
        @(posedge clk);
        #2;
        check("pre_rst_valid", longint'(vld_a), 1);
        rst_n = 1'b0;
        #1;
        check("async_valid_a", longint'(vld_a), 0);
        check("async_data_a", longint'(dat_a), 0);
        check("async_valid_d", longint'(vld_d), 0);
        check("async_data_d", longint'(dat_d), 0);
        in_valid = 1'b0;
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, 8'h2C, 4'h9);
        cycle(1'b0, 1'b1, 8'h00, 4'h0);
        cycle(1'b0, 1'b1, 8'h00, 4'h0);

        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 4'($urandom));
        end
        cycle(1'b0, 1'b1, 8'h00, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_floor_sat_cast.md
Name: fixed_floor_sat_cast

Overview:
- Registered fixed-point signed format converter: floor-rounds the input to the output fraction width, then saturates it to the output integer range.
- Sits between datapath stages whose formats differ, e.g. accumulator → activation, or layer → layer requantisation.
- Uses a valid/ready stream interface with a single pipeline register, so it is back-pressure safe.

Parameters:
- IN_WIDTH, 8, total input bits (two's complement, >0).
- IN_FRAC_WIDTH, 4, input fraction bits (0..IN_WIDTH).
- OUT_WIDTH, 8, total output bits (>0).
- OUT_FRAC_WIDTH, 4, output fraction bits (0..OUT_WIDTH).
- SYMMETRIC, 0, 1 → output range ±(2^(OUT_WIDTH-1)-1); 0 → [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  IN_WIDTH  signed input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input.
- out_data  out  OUT_WIDTH  signed converted sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0. in_ready=1 after reset.
- Rounding stage (combinational):
  - D = OUT_FRAC_WIDTH - IN_FRAC_WIDTH.
  - D ≥ 0: value = in_data sign-extended, then shifted left by D. Width RW = IN_WIDTH + D. Exact, no rounding.
  - D < 0: value = in_data arithmetically shifted right by -D (floor toward -∞; e.g. -0.0625 → -0.5 at 1 fraction bit). Width RW = IN_WIDTH.
- Clamp stage (combinational):
  - MAX = 2^(OUT_WIDTH-1)-1. MIN = -2^(OUT_WIDTH-1), or -MAX when SYMMETRIC=1.
  - value > MAX → MAX; value < MIN → MIN; otherwise the low OUT_WIDTH bits.
  - If RW < OUT_WIDTH, value is sign-extended and then compared the same way, so the SYMMETRIC limit still applies.
- Pipeline:
  - in_ready = !out_valid || out_ready.
  - A transfer occurs on a rising clk edge with in_valid && in_ready. The register captures the clamped value and sets out_valid=1.
  - If out_valid && out_ready and there is no new transfer, out_valid clears. out_data holds its last value.
  - Simultaneous output pop and input push → register reloads; out_valid stays 1. Full throughput, latency 1 cycle.
  - While out_valid=1 and out_ready=0: out_data and out_valid are stable and in_ready=0.
- Reset asserted mid-stream drops the held sample immediately.
- Default parameters give an identity cast.

Optional Feature:
- Macro FIXED_CAST_SAT_FLAG_EN.
- Defined: adds output port out_sat (1 bit). It is registered alongside out_data, reset 0, and equals 1 when the delivered sample was clamped to MAX or MIN (value outside range; values exactly at the limit do not set it).
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package fixed_cast_pkg: function computing RW from the four width parameters; functions returning MAX/MIN for a given OUT_WIDTH and SYMMETRIC.
- One sub-module, fixed_floor_shift (combinational): performs the rounding stage and exposes RW-wide value.
- Clamp, saturation flag and pipeline register are in the top level.

Test Plan:
- Rounding and saturation, with IN 8/4, OUT 4/1, SYMMETRIC=0:
  - in 0x2C (2.75) → out 0x5 (2.5).
  - in 0xFF (-0.0625) → out 0xF (-0.5).
  - in 0x7F → out 0x7 (saturated max; out_sat=1 when FIXED_CAST_SAT_FLAG_EN defined).
  - in 0x80 (-8.0) → out 0x8 (-4.0, saturated min, out_sat=1).
  - Same 0x80 with SYMMETRIC=1 → out 0x9.
- Left shift, IN 4/0, OUT 8/2: in 0x9 (-7) → out 0xE4; in 0x7 → out 0x1C; no saturation.
- Defaults 8/4→8/4: a stream 0x00, 0x7F, 0x80, 0x13 with out_ready=1 → identical values one cycle later, one per cycle, in order.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_data stable. Release → next sample delivered, no loss or duplication.
- Reset: assert rst_n=0 asynchronously while out_valid=1 → out_valid and out_data go to 0 without waiting for a clock edge; first post-reset sample has 1-cycle latency.
